// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter, one word per frame on tx.
// Frame: start(0), din LSB first, optional parity, STOP_BITS ones.
// Back-to-back frames: a start seen in the ready_flag cycle reloads the
// shifter, so no idle cycle separates one frame from the next.
// Optional feature macro: UART_TX_CTS_EN adds a cts_n flow-control input.
// Ports:
//   clk        system clock, posedge
//   rst_n      asynchronous active-low reset
//   start      send request, sampled when idle or in the ready_flag cycle
//   din        word to send, captured on accept
//   cts_n      (UART_TX_CTS_EN only) active-low clear-to-send, async
//   tx         serial line, idle high, driven straight from a flop
//   busy       high while a frame is in flight
//   ready_flag combinational, final clock of the final stop bit
module uart_tx_cfg #(
  parameter int unsigned CLOCK_FREQUENCY = 200000000,
  parameter int unsigned BAUD_RATE       = 9600,
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned PARITY          = 0,
  parameter int unsigned STOP_BITS       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] din,
`ifdef UART_TX_CTS_EN
  input  logic                 cts_n,
`endif
  output logic                 tx,
  output logic                 busy,
  output logic                 ready_flag
);

  localparam int unsigned TIMER_MAX = CLOCK_FREQUENCY / BAUD_RATE - 1;
  localparam int unsigned CNT_W     = (TIMER_MAX > 0) ? $clog2(TIMER_MAX + 1) : 1;
  localparam int unsigned HAS_PAR   = (PARITY != 0) ? 1 : 0;
  localparam int unsigned N_BITS    = 1 + DATA_BITS + HAS_PAR + STOP_BITS;
  localparam int unsigned IDX_W     = $clog2(N_BITS);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [N_BITS-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    baud_q, baud_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic [N_BITS-1:0]   frame_c;
  logic                par_c;
  logic                bit_end_c;
  logic                last_bit_c;
  logic                cts_ok_c;
  logic                accept_c;

  // Clear-to-send qualifier: double-flopped, resets to "not clear"
`ifdef UART_TX_CTS_EN
  logic cts_meta_q, cts_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= cts_n;
      cts_sync_q <= cts_meta_q;
    end
  end

  assign cts_ok_c = ~cts_sync_q;
`else
  assign cts_ok_c = 1'b1;
`endif

  // Odd mode makes the total count of ones odd, even mode makes it even
  assign par_c = (PARITY == 1) ? ~(^din) : (^din);

  // Whole frame laid out LSB-first; unused upper bits stay as stop ones
  always_comb begin
    frame_c              = '1;
    frame_c[0]           = 1'b0;
    frame_c[DATA_BITS:1] = din;
    if (HAS_PAR != 0) begin
      frame_c[DATA_BITS+1] = par_c;
    end
  end

  assign bit_end_c  = (baud_q == CNT_W'(TIMER_MAX));
  assign last_bit_c = (idx_q == IDX_W'(N_BITS - 1));
  assign ready_flag = (state_q == S_SEND) && bit_end_c && last_bit_c;
  assign accept_c   = start && cts_ok_c && ((state_q == S_IDLE) || ready_flag);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d = S_SEND;
          shift_d = frame_c;
          baud_d  = '0;
          idx_d   = '0;
        end
      end
      S_SEND: begin
        if (bit_end_c) begin
          baud_d = '0;
          if (last_bit_c) begin
            idx_d = '0;
            if (accept_c) begin
              shift_d = frame_c;
            end else begin
              state_d = S_IDLE;
              shift_d = '1;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = {1'b1, shift_q[N_BITS-1:1]};
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '1;
      baud_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
    end
  end

  assign tx   = shift_q[0];
  assign busy = (state_q == S_SEND);

endmodule
